// File: rtl/md_audio_mix.sv
// Stereo FM + PSG mixer: per-frame FM accumulation, a one-cycle mix/saturate
// stage and a 4-entry output FIFO with sticky overflow/frame-length flags.
module md_audio_mix #(
  parameter int unsigned FM_SHIFT   = 2,
  parameter int unsigned PSG_SHIFT  = 2,
  parameter logic [15:0] PSG_OFFSET = 16'h0000
) (
  input  logic        MCLK,
  input  logic        SRES,
  input  logic [8:0]  MOL,
  input  logic [8:0]  MOR,
  input  logic        FM_EN,
  input  logic        FM_SYNC,
  input  logic [15:0] PSG,
  output logic [15:0] OUT_L,
  output logic [15:0] OUT_R,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  input  logic        CLR_FLAGS,
  output logic        OVF,
  output logic        FRAME_ERR
);

  localparam int XW = 20;
  localparam logic [4:0]          FRAME_SLOTS = 5'd24;
  localparam logic signed [XW-1:0] SAT_HI     = 20'sd32767;
  localparam logic signed [XW-1:0] SAT_LO     = -20'sd32768;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state;
  logic signed [13:0] r_acc_l, r_acc_r;
  logic [4:0]         r_cnt;
  logic               r_mix_valid;
  logic signed [13:0] r_mix_acc_l, r_mix_acc_r;
  logic [4:0]         r_mix_cnt;
  logic [15:0]        r_mix_psg;

  logic signed [13:0] w_mol_ext, w_mor_ext;
  assign w_mol_ext = {{5{MOL[8]}}, MOL};
  assign w_mor_ext = {{5{MOR[8]}}, MOR};

  // Frame accumulation, slot counter and INIT/RUN sequencing. A sample that
  // coincides with FM_SYNC seeds the new frame rather than closing the old one.
  always_ff @(posedge MCLK) begin
    if (!SRES) begin
      r_state     <= ST_INIT;
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_cnt       <= '0;
      r_mix_valid <= 1'b0;
      r_mix_acc_l <= '0;
      r_mix_acc_r <= '0;
      r_mix_cnt   <= '0;
      r_mix_psg   <= '0;
    end else begin
      // NOTE: non-blocking assignments let this default be overridden below
      // without creating an ordering dependency between statements.
      r_mix_valid <= 1'b0;
      if (FM_SYNC) begin
        r_mix_valid <= (r_state == ST_RUN);
        r_mix_acc_l <= r_acc_l;
        r_mix_acc_r <= r_acc_r;
        r_mix_cnt   <= r_cnt;
        r_mix_psg   <= PSG;
        r_state     <= ST_RUN;
        r_acc_l     <= FM_EN ? w_mol_ext : '0;
        r_acc_r     <= FM_EN ? w_mor_ext : '0;
        r_cnt       <= FM_EN ? 5'd1 : 5'd0;
      end else if (FM_EN) begin
        r_acc_l <= r_acc_l + w_mol_ext;
        r_acc_r <= r_acc_r + w_mor_ext;
        if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  function automatic logic [15:0] sat16(input logic signed [XW-1:0] x);
    if (x > SAT_HI)      return 16'h7FFF;
    else if (x < SAT_LO) return 16'h8000;
    else                 return x[15:0];
  endfunction

  logic signed [XW-1:0] w_psg_diff, w_psg_term, w_fm_l, w_fm_r;
  logic [15:0]          w_sat_l, w_sat_r;
  assign w_psg_diff = $signed(XW'({1'b0, r_mix_psg})) - $signed(XW'(PSG_OFFSET));
  assign w_psg_term = w_psg_diff >>> PSG_SHIFT;
  assign w_fm_l     = $signed({{(XW-14){r_mix_acc_l[13]}}, r_mix_acc_l}) <<< FM_SHIFT;
  assign w_fm_r     = $signed({{(XW-14){r_mix_acc_r[13]}}, r_mix_acc_r}) <<< FM_SHIFT;
  assign w_sat_l    = sat16(w_fm_l + w_psg_term);
  assign w_sat_r    = sat16(w_fm_r + w_psg_term);

  logic [31:0] r_mem [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_occ;
  logic [15:0] r_hold_l, r_hold_r;
  logic        r_ovf, r_ferr;

  logic        w_pop, w_full, w_push_ok, w_drop;
  logic [31:0] w_head;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_pop     = (r_occ != 3'd0) && OUT_READY;
  assign w_full    = (r_occ == 3'd4);
  assign w_push_ok = r_mix_valid && (!w_full || w_pop);
  assign w_drop    = r_mix_valid && w_full && !w_pop;

  // NOTE: storage has no reset; occupancy alone decides what is valid, and
  // leaving the array unreset keeps it a plain register file / RAM.
  always_ff @(posedge MCLK) begin
    if (SRES && w_push_ok) r_mem[r_wr_ptr] <= {w_sat_l, w_sat_r};
  end

  // Pop is applied before push, so a full FIFO that is drained this cycle
  // still accepts the incoming sample. Set events beat CLR_FLAGS.
  always_ff @(posedge MCLK) begin
    if (!SRES) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
        r_hold_l <= w_head[31:16];
        r_hold_r <= w_head[15:0];
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      r_occ <= r_occ + {2'b00, w_push_ok} - {2'b00, w_pop};
      if (w_drop)         r_ovf <= 1'b1;
      else if (CLR_FLAGS) r_ovf <= 1'b0;
      if (r_mix_valid && (r_mix_cnt != FRAME_SLOTS)) r_ferr <= 1'b1;
      else if (CLR_FLAGS)                            r_ferr <= 1'b0;
    end
  end

  assign OUT_VALID = (r_occ != 3'd0);
  assign OUT_L     = OUT_VALID ? w_head[31:16] : r_hold_l;
  assign OUT_R     = OUT_VALID ? w_head[15:0]  : r_hold_r;
  assign OVF       = r_ovf;
  assign FRAME_ERR = r_ferr;

endmodule

// File: doc/md_audio_mix.md
MD_AUDIO_MIX -- requirements
Module: md_audio_mix

Interface
REQ-001 SHALL have parameter FM_SHIFT, default 2: left shift applied to the FM frame sum.
REQ-002 SHALL have parameter PSG_SHIFT, default 2: arithmetic right shift applied to the offset-corrected PSG value.
REQ-003 SHALL have parameter PSG_OFFSET, default 16'h0000: DC offset subtracted from PSG.
REQ-004 SHALL have port MCLK, input, 1: single master clock; all state changes on its rising edge.
REQ-005 SHALL have port SRES, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have ports MOL and MOR, input, 9 each: FM slot outputs, two's complement.
REQ-007 SHALL have port FM_EN, input, 1: FM slot-sample strobe; MOL and MOR are valid when high.
REQ-008 SHALL have port FM_SYNC, input, 1: one-cycle pulse marking the first slot of an FM output frame.
REQ-009 SHALL have port PSG, input, 16: unsigned PSG mix level.
REQ-010 SHALL have ports OUT_L and OUT_R, output, 16 each: signed stereo sample at the FIFO head.
REQ-011 SHALL have port OUT_VALID, output, 1: FIFO non-empty.
REQ-012 SHALL have port OUT_READY, input, 1: consumer accepts the head entry when high together with OUT_VALID.
REQ-013 SHALL have port CLR_FLAGS, input, 1: clears the sticky flags.
REQ-014 SHALL have ports OVF and FRAME_ERR, output, 1 each: sticky flags.

Function
REQ-015 SHALL accumulate MOL and MOR (sign-extended) into 14-bit signed sums ACC_L and ACC_R on every cycle with FM_EN=1.
REQ-016 SHALL count FM_EN strobes per frame in a 5-bit counter that saturates at 31.
REQ-017 On FM_SYNC=1, SHALL latch ACC_L, ACC_R, the count and PSG into the mix stage, then reload the accumulators with the current sample (if FM_EN=1) or with 0.
REQ-018 On FM_SYNC=1, SHALL reload the counter to 1 if FM_EN=1, else to 0.
REQ-019 When FM_SYNC and FM_EN coincide, the sample on that cycle SHALL belong to the new frame.
REQ-020 SHALL implement a two-state FSM, INIT -> RUN: the first FM_SYNC in INIT moves to RUN and pushes nothing (partial frame); each FM_SYNC in RUN produces one push.
REQ-021 Mix stage (one cycle after FM_SYNC) SHALL compute X = (ACC_x <<< FM_SHIFT) + (({1'b0,PSG} - PSG_OFFSET) >>> PSG_SHIFT), using at least 18-bit signed arithmetic, for x in L and R.
REQ-022 X SHALL saturate to [-32768, 32767].
REQ-023 The saturated result SHALL be pushed into a 4-entry FIFO on the cycle after the mix stage.
REQ-024 Latency SHALL be FM_SYNC at cycle N -> OUT_VALID=1 at cycle N+2 when the FIFO is empty.
REQ-025 OUT_L and OUT_R SHALL show the FIFO head whenever OUT_VALID=1, and SHALL hold the last popped value otherwise.
REQ-026 A pop SHALL occur when OUT_VALID and OUT_READY are both 1.
REQ-027 FIFO SHALL apply a pop before a push in the same cycle, so a push at full together with a pop is accepted.
REQ-028 A push at full without a pop SHALL drop the new sample and set OVF.
REQ-029 Pointers SHALL wrap modulo 4; occupancy SHALL be held in a 3-bit counter in the range 0..4.
REQ-030 FRAME_ERR SHALL be set when a RUN-state FM_SYNC latches a count other than 24; the sample is still pushed.
REQ-031 CLR_FLAGS SHALL clear OVF and FRAME_ERR; a set event in the same cycle SHALL win.
REQ-032 FM_SYNC pulses closer together than the 2-cycle pipeline SHALL each produce a push; the pipeline SHALL be fully pipelined with no stall.

Reset
REQ-033 SRES=0 at a rising MCLK edge SHALL clear the accumulators, counter, mix registers, FIFO pointers and occupancy, and set the FSM to INIT.
REQ-034 During SRES=0, OUT_L = OUT_R = 0, OUT_VALID = 0, OVF = 0 and FRAME_ERR = 0.
REQ-035 SRES=0 during operation SHALL discard any in-flight mix-stage result and all FIFO contents.
REQ-036 While SRES=0, all other inputs SHALL be ignored.

Verification
REQ-037 After reset, one FM_SYNC, then 24 FM_EN strobes with MOL=+10, MOR=-10, PSG=0, then FM_SYNC -> no push from the first sync; at sync+2, OUT_L=960, OUT_R=-960, OUT_VALID=1.
REQ-038 In RUN, 24 strobes with MOL=MOR=+255, PSG=16'hFFFF, FM_SHIFT=2 -> OUT_L=OUT_R=32767 (saturated).
REQ-039 With OUT_READY=0, five RUN frames -> OUT_VALID=1, occupancy 4, OVF=1, and the fifth sample is lost; then OUT_READY=1 -> four pops in order.
REQ-040 With the FIFO full, OUT_READY=1 and a push in the same cycle -> occupancy stays 4 and OVF stays 0.
REQ-041 A frame with 23 strobes -> FRAME_ERR=1 and the sample is pushed; CLR_FLAGS pulse -> FRAME_ERR=0.
REQ-042 SRES=0 asserted one cycle after FM_SYNC -> no push; OUT_VALID=0; FSM in INIT.
